// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle RV32I-subset core: FSM states, ALU codes,
// opcodes and datapath mux selects.
package ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECR, EXECI, ALUWB, BRANCH, JAL
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] SRC_A_PC    = 2'b00;
  localparam logic [1:0] SRC_A_OLDPC = 2'b01;
  localparam logic [1:0] SRC_A_REG   = 2'b10;

  localparam logic [1:0] SRC_B_REG  = 2'b00;
  localparam logic [1:0] SRC_B_IMM  = 2'b01;
  localparam logic [1:0] SRC_B_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  function automatic logic [1:0] imm_sel(input logic [6:0] op);
    case (op)
      OP_SW:   return IMM_S;
      OP_BR:   return IMM_B;
      OP_JAL:  return IMM_J;
      default: return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_alu_dec.sv
// ALU control decoder: maps the FSM's aluop request plus funct fields to the
// 3-bit ALU code, flagging unsupported funct3 values.
module alu_dec
  import ctrl_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       rtype,
  output logic [2:0] alu_ctrl,
  output logic       illegal
);

  always_comb begin
    alu_ctrl = ALU_ADD;
    illegal  = 1'b0;
    case (aluop)
      ALUOP_SUB: alu_ctrl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  alu_ctrl = (rtype && funct7_5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_ctrl = ALU_SLT;
          3'b110:  alu_ctrl = ALU_OR;
          3'b111:  alu_ctrl = ALU_AND;
          default: illegal  = 1'b1;
        endcase
      end
      default: alu_ctrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM for the RV32I-subset core. The state register is the
// only flop; every output is decoded combinationally from state and inputs.
module multicycle_ctrl
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       eq,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_ctrl,
  output logic [1:0] result_src,
  output logic [1:0] imm_src,
  output logic       illegal
);

  state_t     state, state_next;
  logic [1:0] aluop;
  logic       rtype;
  logic       fsm_illegal;
  logic       dec_illegal;

  alu_dec u_alu_dec (
    .aluop    (aluop),
    .funct3   (funct3),
    .funct7_5 (funct7_5),
    .rtype    (rtype),
    .alu_ctrl (alu_ctrl),
    .illegal  (dec_illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FETCH;
    else        state <= state_next;
  end

  assign imm_src = imm_sel(op);
  assign illegal = fsm_illegal | dec_illegal;

  always_comb begin
    state_next  = state;
    mem_req     = 1'b0;
    mem_write   = 1'b0;
    adr_src     = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    reg_write   = 1'b0;
    alu_src_a   = SRC_A_PC;
    alu_src_b   = SRC_B_REG;
    result_src  = RES_ALUOUT;
    aluop       = ALUOP_ADD;
    rtype       = 1'b0;
    fsm_illegal = 1'b0;
    case (state)
      FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = SRC_B_FOUR;
        result_src = RES_ALU;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
        if (mem_ready) state_next = DECODE;
      end
      DECODE: begin
        // Branch/jump target is precomputed into ALUOut here.
        alu_src_a = SRC_A_OLDPC;
        alu_src_b = SRC_B_IMM;
        case (op)
          OP_LW, OP_SW: state_next = MEMADR;
          OP_R:         state_next = EXECR;
          OP_I:         state_next = EXECI;
          OP_BR:        state_next = BRANCH;
          OP_JAL:       state_next = JAL;
          default: begin
            fsm_illegal = 1'b1;
            state_next  = FETCH;
          end
        endcase
      end
      MEMADR: begin
        alu_src_a  = SRC_A_REG;
        alu_src_b  = SRC_B_IMM;
        state_next = (op == OP_SW) ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (mem_ready) state_next = MEMWB;
      end
      MEMWB: begin
        result_src = RES_DATA;
        reg_write  = 1'b1;
        state_next = FETCH;
      end
      MEMWRITE: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        adr_src   = 1'b1;
        if (mem_ready) state_next = FETCH;
      end
      EXECR, EXECI: begin
        alu_src_a  = SRC_A_REG;
        alu_src_b  = (state == EXECI) ? SRC_B_IMM : SRC_B_REG;
        aluop      = ALUOP_FUNCT;
        rtype      = (state == EXECR);
        state_next = ALUWB;
      end
      ALUWB: begin
        result_src = RES_ALUOUT;
        reg_write  = 1'b1;
        state_next = FETCH;
      end
      BRANCH: begin
        alu_src_a  = SRC_A_REG;
        alu_src_b  = SRC_B_REG;
        aluop      = ALUOP_SUB;
        result_src = RES_ALUOUT;
        case (funct3)
          3'b000:  pc_write    = eq;
          3'b001:  pc_write    = !eq;
          default: fsm_illegal = 1'b1;
        endcase
        state_next = FETCH;
      end
      JAL: begin
        alu_src_a  = SRC_A_OLDPC;
        alu_src_b  = SRC_B_FOUR;
        result_src = RES_ALUOUT;
        pc_write   = 1'b1;
        state_next = ALUWB;
      end
      default: state_next = FETCH;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: each instruction is expanded into its
// expected per-cycle output list from the instruction-level rules, then replayed.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7_5, eq, mem_ready;
  logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
  logic [1:0] alu_src_a, alu_src_b, result_src, imm_src;
  logic [2:0] alu_ctrl;
  logic       illegal;

  multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7_5(funct7_5),
    .eq(eq), .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write),
    .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_ctrl(alu_ctrl), .result_src(result_src), .imm_src(imm_src),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
    logic [1:0] sa, sb;
    logic [2:0] alu;
    logic [1:0] rs, imm;
    logic       ill;
  } vec_t;

  vec_t obs;
  always_comb obs = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                     alu_src_a, alu_src_b, alu_ctrl, result_src, imm_src, illegal};

  int   tests = 0;
  int   fails = 0;
  vec_t q[$];
  bit   waits[$];

  task automatic check(input string tag, input vec_t e);
    tests++;
    assert (obs === e) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, e);
    end
  endtask

  task automatic check_int(input string tag, input int o, input int e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
    end
  endtask

  function automatic logic [1:0] imm_of(input logic [6:0] o);
    if (o == 7'b0100011) return 2'b01;
    if (o == 7'b1100011) return 2'b10;
    if (o == 7'b1101111) return 2'b11;
    return 2'b00;
  endfunction

  // Returns {illegal, alu code} for an arithmetic instruction.
  function automatic logic [3:0] funct_alu(input logic [2:0] f3, input logic f75, input logic rt);
    if (f3 == 3'b000) return (rt && f75) ? 4'b0001 : 4'b0000;
    if (f3 == 3'b010) return 4'b0101;
    if (f3 == 3'b110) return 4'b0011;
    if (f3 == 3'b111) return 4'b0010;
    return 4'b1000;
  endfunction

  task automatic push(input vec_t v, input bit w);
    q.push_back(v);
    waits.push_back(w);
  endtask

  task automatic build(input logic [6:0] o, input logic [2:0] f3, input logic f75, input logic e);
    vec_t base, s;
    logic [3:0] fa;
    q.delete();
    waits.delete();
    base = '0;
    base.imm = imm_of(o);
    s = base; s.mem_req = 1; s.ir_write = 1; s.pc_write = 1; s.sb = 2'b10; s.rs = 2'b10;
    push(s, 1);
    s = base; s.sa = 2'b01; s.sb = 2'b01;
    if (!(o inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111}))
      s.ill = 1;
    push(s, 0);
    if (o == 7'b0000011 || o == 7'b0100011) begin
      s = base; s.sa = 2'b10; s.sb = 2'b01;
      push(s, 0);
      s = base; s.mem_req = 1; s.adr_src = 1; s.mem_write = (o == 7'b0100011);
      push(s, 1);
      if (o == 7'b0000011) begin
        s = base; s.rs = 2'b01; s.reg_write = 1;
        push(s, 0);
      end
    end else if (o == 7'b0110011 || o == 7'b0010011) begin
      fa = funct_alu(f3, f75, o == 7'b0110011);
      s = base; s.sa = 2'b10; s.sb = (o == 7'b0010011) ? 2'b01 : 2'b00;
      s.alu = fa[2:0]; s.ill = fa[3];
      push(s, 0);
      s = base; s.reg_write = 1;
      push(s, 0);
    end else if (o == 7'b1100011) begin
      s = base; s.sa = 2'b10; s.alu = 3'b001;
      s.pc_write = (f3 == 3'b000) ? e : (f3 == 3'b001) ? !e : 1'b0;
      s.ill = (f3 > 3'b001);
      push(s, 0);
    end else if (o == 7'b1101111) begin
      s = base; s.sa = 2'b01; s.sb = 2'b10; s.pc_write = 1;
      push(s, 0);
      s = base; s.reg_write = 1;
      push(s, 0);
    end
  endtask

  // Entered and left at posedge+1; outputs are compared mid-cycle.
  task automatic run_instr(input string name, input logic [6:0] o, input logic [2:0] f3,
                           input logic f75, input logic e, input int fstall, input int mstall,
                           input int abort_at, output int cycles, output int writes);
    vec_t x;
    int   stall;
    build(o, f3, f75, e);
    op = o; funct3 = f3; funct7_5 = f75; eq = e;
    cycles = 0;
    writes = 0;
    for (int k = 0; k < q.size(); k++) begin
      stall = (k == 0) ? fstall : mstall;
      if (waits[k]) begin
        for (int j = 0; j < stall; j++) begin
          mem_ready = 1'b0;
          #4;
          x = q[k]; x.ir_write = 0; x.pc_write = 0;
          check({name, "_stall"}, x);
          cycles++;
          writes += int'(reg_write);
          @(posedge clk); #1;
        end
        mem_ready = 1'b1;
      end else begin
        mem_ready = 1'($urandom_range(1, 0));
      end
      #4;
      check(name, q[k]);
      cycles++;
      writes += int'(reg_write);
      if (k == abort_at) begin
        #1 rst_n = 1'b0;
        #1;
        x = '0; x.mem_req = 1; x.ir_write = mem_ready; x.pc_write = mem_ready;
        x.sb = 2'b10; x.rs = 2'b10; x.imm = imm_of(o);
        check({name, "_reset"}, x);
        @(posedge clk); #1 rst_n = 1'b1;
        return;
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int   cyc, wr, fs, ms;
    vec_t r;
    logic [6:0] ops[7];
    ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111, 7'b0000000};
    rst_n = 1'b0; op = 7'b0110011; funct3 = '0; funct7_5 = 0; eq = 0; mem_ready = 0;
    #2;
    r = '0; r.mem_req = 1; r.sb = 2'b10; r.rs = 2'b10;
    check("reset_rdy0", r);
    mem_ready = 1; #1;
    r.ir_write = 1; r.pc_write = 1;
    check("reset_rdy1", r);
    @(posedge clk); #1 rst_n = 1'b1;

    run_instr("lw_stall", 7'b0000011, 3'b010, 0, 0, 2, 2, -1, cyc, wr);
    check_int("lw_stall_cycles", cyc, 9);
    check_int("lw_stall_writes", wr, 1);
    run_instr("lw_abort", 7'b0000011, 3'b010, 0, 0, 0, 0, 4, cyc, wr);
    run_instr("lw_after_reset", 7'b0000011, 3'b010, 0, 0, 0, 0, -1, cyc, wr);
    check_int("lw_cycles", cyc, 5);
    run_instr("r_sub", 7'b0110011, 3'b000, 1, 0, 0, 0, -1, cyc, wr);
    check_int("r_cycles", cyc, 4);
    run_instr("addi_f75", 7'b0010011, 3'b000, 1, 0, 0, 0, -1, cyc, wr);
    run_instr("beq_t", 7'b1100011, 3'b000, 0, 1, 0, 0, -1, cyc, wr);
    check_int("br_cycles", cyc, 3);
    run_instr("beq_nt", 7'b1100011, 3'b000, 0, 0, 0, 0, -1, cyc, wr);
    run_instr("bne_eq1", 7'b1100011, 3'b001, 0, 1, 0, 0, -1, cyc, wr);
    run_instr("bne_eq0", 7'b1100011, 3'b001, 0, 0, 0, 0, -1, cyc, wr);
    run_instr("br_f100", 7'b1100011, 3'b100, 0, 1, 0, 0, -1, cyc, wr);
    run_instr("slti", 7'b0010011, 3'b010, 0, 0, 0, 0, -1, cyc, wr);
    run_instr("ori", 7'b0010011, 3'b110, 0, 0, 0, 0, -1, cyc, wr);
    run_instr("andi", 7'b0010011, 3'b111, 0, 0, 0, 0, -1, cyc, wr);
    run_instr("r_bad_f3", 7'b0110011, 3'b011, 0, 0, 0, 0, -1, cyc, wr);
    run_instr("ill_op", 7'b1110011, 3'b000, 0, 0, 0, 0, -1, cyc, wr);
    check_int("ill_cycles", cyc, 2);
    check_int("ill_writes", wr, 0);
    run_instr("sw", 7'b0100011, 3'b010, 0, 0, 0, 1, -1, cyc, wr);
    check_int("sw_cycles", cyc, 5);
    run_instr("jal", 7'b1101111, 3'b000, 0, 0, 0, 0, -1, cyc, wr);
    check_int("jal_cycles", cyc, 4);

    for (int n = 0; n < 80; n++) begin
      fs = $urandom_range(3, 0);
      ms = $urandom_range(3, 0);
      run_instr("rand", ops[$urandom_range(6, 0)], 3'($urandom_range(7, 0)),
                1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), fs, ms, -1, cyc, wr);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multicycle control FSM that drives the ALU and the datapath muxes of the RV32I subset core. It sequences fetch, decode, execute, memory and writeback over several cycles. It produces the 3-bit ALU control code the ALU consumes and takes back the ALU's `eq` flag to resolve branches. Memory accesses use a request/ready handshake, so the FSM stalls on slow memory.

## Interface
Parameters: none (all encodings come from `ctrl_pkg`).

- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `op`  in  7  instruction opcode (IR[6:0])
- `funct3`  in  3  IR[14:12]
- `funct7_5`  in  1  IR[30]
- `eq`  in  1  ALU equality flag (src1 == src2)
- `mem_ready`  in  1  memory completed the current request this cycle
- `mem_req`  out  1  memory access request
- `mem_write`  out  1  store strobe; valid only with `mem_req`
- `adr_src`  out  1  memory address select: 0 = PC, 1 = ALUOut
- `ir_write`  out  1  load IR and OldPC
- `pc_write`  out  1  load PC from the result bus
- `reg_write`  out  1  register-file write enable
- `alu_src_a`  out  2  ALU src1 select: 00 = PC, 01 = OldPC, 10 = reg A
- `alu_src_b`  out  2  ALU src2 select: 00 = reg B, 01 = ImmExt, 10 = constant 4
- `alu_ctrl`  out  3  ALU control code
- `result_src`  out  2  result bus select: 00 = ALUOut, 01 = Data, 10 = ALU result
- `imm_src`  out  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J
- `illegal`  out  1  one-cycle pulse on an unsupported opcode or funct

## Operation
- ALU codes:
  - 000 = add
  - 001 = sub
  - 010 = and
  - 011 = or
  - 101 = slt
  - 110, 111 and 100 are never driven.
- FSM states: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL.
- FETCH:
  - Drives `mem_req=1`, `adr_src=0`, `alu_src_a=00`, `alu_src_b=10`, `alu_ctrl=add`, `result_src=10`.
  - `ir_write` and `pc_write` equal `mem_ready`.
  - Stays in FETCH until `mem_ready`, then goes to DECODE.
- DECODE: drives `alu_src_a=01`, `alu_src_b=01`, `alu_ctrl=add` (branch/jump target into ALUOut). Next state by `op`:
  - 0000011 (lw) or 0100011 (sw) → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1100011 → BRANCH
  - 1101111 → JAL
  - any other opcode → FETCH, with `illegal` pulsed in DECODE.
- MEMADR: drives `alu_src_a=10`, `alu_src_b=01`, `alu_ctrl=add`. Goes to MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: drives `mem_req=1`, `adr_src=1`; waits for `mem_ready`, then MEMWB.
- MEMWB: drives `result_src=01`, `reg_write=1`; then FETCH.
- MEMWRITE: drives `mem_req=1`, `mem_write=1`, `adr_src=1`; waits for `mem_ready`, then FETCH.
- EXECR / EXECI: drive `alu_src_a=10`, with `alu_src_b` = 00 / 01 respectively, and `alu_ctrl` from the funct decode below. Then ALUWB.
- ALUWB: drives `result_src=00`, `reg_write=1`; then FETCH.
- BRANCH: drives `alu_src_a=10`, `alu_src_b=00`, `alu_ctrl=sub`, `result_src=00`; then FETCH.
  - funct3=000 (beq): `pc_write=eq`.
  - funct3=001 (bne): `pc_write=!eq`.
  - any other funct3: `pc_write=0` and `illegal` pulses.
- JAL: drives `alu_src_a=01`, `alu_src_b=10`, `alu_ctrl=add`, `result_src=00`, `pc_write=1`; then ALUWB (writes PC+4 to rd).
- Funct decode (EXECR/EXECI):
  - funct3 000: sub only when R-type and `funct7_5=1`; otherwise add.
  - funct3 010 → slt; 110 → or; 111 → and.
  - Any other funct3 → add with an `illegal` pulse. The instruction still writes back.
- `imm_src` is decoded from `op` in every state: sw → 01, branch → 10, jal → 11, everything else → 00.
- Every output not listed for a state is 0.

## Timing
- All outputs are combinational from the state register plus `op`/`funct3`/`funct7_5`/`eq`/`mem_ready`. There are no registered outputs; the state register is the only flop.
- Reset: `rst_n` low puts the FSM in FETCH immediately (asynchronous). During reset the outputs are FETCH outputs:
  - `mem_req=1`
  - `ir_write` and `pc_write` follow `mem_ready`
  - all other outputs 0, except `alu_src_b=10` and `result_src=10`.
  - The datapath holds PC in reset, so these outputs are harmless.
- Reset mid-instruction abandons that instruction. No further `reg_write` or `mem_write` is issued for it.
- Cycles per instruction with `mem_ready` held high: lw 5, sw 4, R/I 4, branch 3, jal 4.
- Each cycle of `mem_ready=0` in FETCH, MEMREAD or MEMWRITE adds one cycle.
- `mem_req` stays asserted with stable `adr_src` and `mem_write` until the `mem_ready` cycle.
- `mem_ready` seen outside FETCH, MEMREAD or MEMWRITE is ignored.

## Structure
- `ctrl_pkg` holds:
  - `state_t` enum
  - ALU code localparams (`ALU_ADD`, `ALU_SUB`, `ALU_AND`, `ALU_OR`, `ALU_SLT`)
  - opcode constants
  - src_a / src_b / result / imm select encodings.
  - The ALU and datapath import the same package.
- One combinational sub-module, `alu_dec`. Inputs: aluop (00 = add, 01 = sub, 10 = funct), funct3, funct7_5, an R-type flag. Outputs: `alu_ctrl`, `illegal`.

## Test plan
- Reset check: assert `rst_n=0` during MEMWB of a lw → `reg_write` drops to 0 immediately. After release, FETCH with `mem_req=1`, `alu_src_b=10`.
- lw with `mem_ready` low for 2 cycles in both FETCH and MEMREAD → 9 cycles total; `reg_write=1`, `result_src=01` exactly once.
- R-type sub (`op`=0110011, funct3=000, `funct7_5=1`) → `alu_ctrl=001` in EXECR. The same operands with `op`=0010011 (addi) → 000.
- Branches:
  - beq with `eq=1` → `pc_write=1` in BRANCH; with `eq=0` → 0.
  - bne inverts both cases.
  - funct3=100 → `pc_write=0` and `illegal` pulses.
- slti (funct3=010) → `alu_ctrl=101`. ori → 011. andi → 010.
- Illegal opcode 1110011 → `illegal` high for the single DECODE cycle, then FETCH; no `reg_write`, `mem_write` or `pc_write` issued.
